// File: rtl/neuron_layer_scheduler_pkg.sv
// Shared types for the layer scheduler: FSM state encoding and a slot offset helper
// for the packed per-neuron result vector.
package neuron_layer_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_WAIT_RD = 3'd2,
    ST_ISSUE   = 3'd3,
    ST_COLLECT = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  // Low bit of W-bit slot k in a packed vector of slots.
  function automatic int slot_lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/neuron_layer_scheduler_handshake_issue.sv
// Three independent valid/accepted flags for the neuron-side issue; all_done fires in
// the cycle where the last outstanding channel transfers.
module neuron_layer_scheduler_handshake_issue (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       active,
  input  logic [2:0] ready,
  output logic [2:0] valid,
  output logic       all_done
);

  logic [2:0] acc_q, acc_d, fire;

  always_comb begin
    valid    = active ? ~acc_q : 3'b000;
    fire     = valid & ready;
    all_done = active && (&(acc_q | fire));
    acc_d    = (active && !all_done) ? (acc_q | fire) : 3'b000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= 3'b000;
    else        acc_q <= acc_d;
  end

endmodule

// File: rtl/neuron_layer_scheduler.sv
// Runs one shared neuron across every output neuron of a layer: fetch weight row,
// issue the three neuron transfers, collect the sum into the layer result vector.
//
// state   | meaning
// IDLE    | waiting for layer_valid; layer_ready high
// FETCH   | weight_rd_en for row base+idx
// WAIT_RD | capture weight_rd_data into the weights register
// ISSUE   | input_number/inputs/weights valids up until each transfers
// COLLECT | neuron_sum_ready high; store sum/overflow in slot idx
// DONE    | layer_outputs_valid high until layer_outputs_ready
module neuron_layer_scheduler
  import neuron_layer_scheduler_pkg::*;
#(
  parameter int NEURON_NUM          = 5,
  parameter int NEURON_OUTPUT_WIDTH = 10,
  parameter int WEIGHT_CELL_WIDTH   = 16,
  parameter int LAYER_MAX           = 8,
  parameter int ADDR_WIDTH          = 8
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       layer_valid,
  output logic                                       layer_ready,
  input  logic [$clog2(NEURON_NUM):0]                layer_input_num,
  input  logic [$clog2(LAYER_MAX):0]                 layer_neuron_num,
  input  logic [ADDR_WIDTH-1:0]                      layer_weight_base,
  input  logic [NEURON_NUM*NEURON_OUTPUT_WIDTH-1:0]  layer_inputs,
  output logic                                       weight_rd_en,
  output logic [ADDR_WIDTH-1:0]                      weight_rd_addr,
  input  logic [NEURON_NUM*WEIGHT_CELL_WIDTH-1:0]    weight_rd_data,
  output logic [$clog2(NEURON_NUM):0]                input_number,
  output logic                                       input_number_valid,
  input  logic                                       input_number_ready,
  output logic [NEURON_NUM*NEURON_OUTPUT_WIDTH-1:0]  inputs,
  output logic                                       inputs_valid,
  input  logic                                       inputs_ready,
  output logic [NEURON_NUM*WEIGHT_CELL_WIDTH-1:0]    weights,
  output logic                                       weights_valid,
  input  logic                                       weights_ready,
  input  logic [NEURON_OUTPUT_WIDTH-1:0]             neuron_sum,
  input  logic                                       overflow,
  input  logic                                       neuron_sum_valid,
  output logic                                       neuron_sum_ready,
  output logic [LAYER_MAX*NEURON_OUTPUT_WIDTH-1:0]   layer_outputs,
  output logic [LAYER_MAX-1:0]                       layer_overflow,
  output logic                                       layer_outputs_valid,
  input  logic                                       layer_outputs_ready
);

  localparam int IN_W  = $clog2(NEURON_NUM) + 1;
  localparam int CNT_W = $clog2(LAYER_MAX) + 1;
  localparam int IDX_W = $clog2(LAYER_MAX);

  state_e                                     state_q, state_d;
  logic [IDX_W-1:0]                           idx_q, idx_d;
  logic [CNT_W-1:0]                           cnt_q, cnt_d;
  logic [IN_W-1:0]                            in_num_q, in_num_d;
  logic [ADDR_WIDTH-1:0]                      base_q, base_d;
  logic [NEURON_NUM*NEURON_OUTPUT_WIDTH-1:0]  inputs_q, inputs_d;
  logic [NEURON_NUM*WEIGHT_CELL_WIDTH-1:0]    weights_q, weights_d;
  logic [LAYER_MAX*NEURON_OUTPUT_WIDTH-1:0]   outs_q, outs_d;
  logic [LAYER_MAX-1:0]                       ovf_q, ovf_d;

  logic [IN_W-1:0]  in_num_sat;
  logic [CNT_W-1:0] cnt_sat;
  logic [2:0]       issue_valid;
  logic             issue_done;

  assign in_num_sat = (layer_input_num > IN_W'(NEURON_NUM)) ? IN_W'(NEURON_NUM) : layer_input_num;
  assign cnt_sat    = (layer_neuron_num > CNT_W'(LAYER_MAX)) ? CNT_W'(LAYER_MAX) : layer_neuron_num;

  // Channel order: 0 = input_number, 1 = inputs, 2 = weights.
  neuron_layer_scheduler_handshake_issue u_issue (
    .clk      (clk),
    .rst_n    (rst),
    .active   (state_q == ST_ISSUE),
    .ready    ({weights_ready, inputs_ready, input_number_ready}),
    .valid    (issue_valid),
    .all_done (issue_done)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    in_num_d  = in_num_q;
    base_d    = base_q;
    inputs_d  = inputs_q;
    weights_d = weights_q;
    outs_d    = outs_q;
    ovf_d     = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (layer_valid) begin
          inputs_d = layer_inputs;
          base_d   = layer_weight_base;
          in_num_d = in_num_sat;
          cnt_d    = cnt_sat;
          outs_d   = '0;
          ovf_d    = '0;
          idx_d    = '0;
          state_d  = (cnt_sat == '0) ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH:   state_d = ST_WAIT_RD;
      ST_WAIT_RD: begin
        weights_d = weight_rd_data;
        state_d   = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (issue_done) state_d = ST_COLLECT;
      end
      ST_COLLECT: begin
        if (neuron_sum_valid) begin
          for (int k = 0; k < LAYER_MAX; k++) begin
            if (idx_q == IDX_W'(k))
              outs_d[slot_lo(k, NEURON_OUTPUT_WIDTH) +: NEURON_OUTPUT_WIDTH] = neuron_sum;
          end
          ovf_d[idx_q] = overflow;
          if (CNT_W'(idx_q) == cnt_q - CNT_W'(1)) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_FETCH;
          end
        end
      end
      ST_DONE: begin
        if (layer_outputs_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      in_num_q  <= '0;
      base_q    <= '0;
      inputs_q  <= '0;
      weights_q <= '0;
      outs_q    <= '0;
      ovf_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      in_num_q  <= in_num_d;
      base_q    <= base_d;
      inputs_q  <= inputs_d;
      weights_q <= weights_d;
      outs_q    <= outs_d;
      ovf_q     <= ovf_d;
    end
  end

  assign layer_ready         = (state_q == ST_IDLE);
  assign weight_rd_en        = (state_q == ST_FETCH);
  assign weight_rd_addr      = base_q + ADDR_WIDTH'(idx_q);
  assign input_number        = in_num_q;
  assign inputs              = inputs_q;
  assign weights             = weights_q;
  assign input_number_valid  = issue_valid[0];
  assign inputs_valid        = issue_valid[1];
  assign weights_valid       = issue_valid[2];
  assign neuron_sum_ready    = (state_q == ST_COLLECT);
  assign layer_outputs       = outs_q;
  assign layer_overflow      = ovf_q;
  assign layer_outputs_valid = (state_q == ST_DONE);

endmodule

// File: tb/tb_neuron_layer_scheduler.sv
// Scoreboard bench for neuron_layer_scheduler with a weight memory model and a
// behavioural neuron (sum of products shifted right by one fraction bit).
module tb_neuron_layer_scheduler;

  logic        clk, rst;
  logic        layer_valid, layer_ready;
  logic [3:0]  layer_input_num, layer_neuron_num;
  logic [7:0]  layer_weight_base;
  logic [49:0] layer_inputs;
  logic        weight_rd_en;
  logic [7:0]  weight_rd_addr;
  logic [79:0] weight_rd_data;
  logic [3:0]  input_number;
  logic        input_number_valid, input_number_ready;
  logic [49:0] inputs;
  logic        inputs_valid, inputs_ready;
  logic [79:0] weights;
  logic        weights_valid, weights_ready;
  logic [9:0]  neuron_sum;
  logic        overflow, neuron_sum_valid, neuron_sum_ready;
  logic [79:0] layer_outputs;
  logic [7:0]  layer_overflow;
  logic        layer_outputs_valid, layer_outputs_ready;

  neuron_layer_scheduler dut (
    .clk(clk), .rst(rst),
    .layer_valid(layer_valid), .layer_ready(layer_ready),
    .layer_input_num(layer_input_num), .layer_neuron_num(layer_neuron_num),
    .layer_weight_base(layer_weight_base), .layer_inputs(layer_inputs),
    .weight_rd_en(weight_rd_en), .weight_rd_addr(weight_rd_addr), .weight_rd_data(weight_rd_data),
    .input_number(input_number), .input_number_valid(input_number_valid),
    .input_number_ready(input_number_ready),
    .inputs(inputs), .inputs_valid(inputs_valid), .inputs_ready(inputs_ready),
    .weights(weights), .weights_valid(weights_valid), .weights_ready(weights_ready),
    .neuron_sum(neuron_sum), .overflow(overflow),
    .neuron_sum_valid(neuron_sum_valid), .neuron_sum_ready(neuron_sum_ready),
    .layer_outputs(layer_outputs), .layer_overflow(layer_overflow),
    .layer_outputs_valid(layer_outputs_valid), .layer_outputs_ready(layer_outputs_ready)
  );

  typedef struct packed {
    logic [79:0] outs;
    logic [7:0]  ovf;
  } res_t;

  int          checks = 0;
  int          errors = 0;
  res_t        exp_res_q[$];
  logic [7:0]  exp_addr_q[$];
  logic [3:0]  exp_in_num;
  logic [49:0] cur_inputs;
  logic        bp_mode;
  int          neuron_lat;
  int          rst_count = 0;
  logic [79:0] wmem [0:255];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge rst) rst_count++;

  always @(posedge clk) if (weight_rd_en) weight_rd_data <= wmem[weight_rd_addr];

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [49:0] pk_in(input int a4, input int a3, input int a2, input int a1, input int a0);
    return {10'(a4), 10'(a3), 10'(a2), 10'(a1), 10'(a0)};
  endfunction

  function automatic logic [79:0] pk_w(input int a4, input int a3, input int a2, input int a1, input int a0);
    return {16'(a4), 16'(a3), 16'(a2), 16'(a1), 16'(a0)};
  endfunction

  function automatic logic [79:0] pk_out(input int s7, input int s6, input int s5, input int s4,
                                         input int s3, input int s2, input int s1, input int s0);
    return {10'(s7), 10'(s6), 10'(s5), 10'(s4), 10'(s3), 10'(s2), 10'(s1), 10'(s0)};
  endfunction

  // Behavioural neuron
  logic        got_n, got_i, got_w;
  logic [3:0]  n_cap;
  logic [49:0] i_cap;
  logic [79:0] w_cap;
  int          bp_cnt, acc, rc, guard;

  initial begin
    neuron_sum_valid = 1'b0; neuron_sum = '0; overflow = 1'b0;
    got_n = 1'b0; got_i = 1'b0; got_w = 1'b0; bp_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        got_n = 1'b0; got_i = 1'b0; got_w = 1'b0; bp_cnt = 0;
      end else begin
        if (bp_mode && got_n && got_w && !got_i) begin
          chk("bp_inputs_valid", 80'(inputs_valid), 80'(1));
          chk("bp_inputs_stable", 80'(inputs), 80'(cur_inputs));
          chk("bp_num_dropped", 80'(input_number_valid), 80'(0));
          chk("bp_w_dropped", 80'(weights_valid), 80'(0));
          bp_cnt++;
          if (bp_cnt == 5) inputs_ready = 1'b1;
        end
        if (input_number_valid && input_number_ready) begin
          got_n = 1'b1; n_cap = input_number;
          chk("input_number", 80'(input_number), 80'(exp_in_num));
        end
        if (inputs_valid && inputs_ready) begin
          got_i = 1'b1; i_cap = inputs;
          chk("neuron_inputs", 80'(inputs), 80'(cur_inputs));
        end
        if (weights_valid && weights_ready) begin
          got_w = 1'b1; w_cap = weights;
        end
        if (got_n && got_i && got_w) begin
          acc = 0;
          for (int k = 0; k < 5; k++)
            if (k < int'(n_cap)) acc += int'(i_cap[k*10 +: 10]) * int'(w_cap[k*16 +: 16]);
          acc = acc >> 1;
          got_n = 1'b0; got_i = 1'b0; got_w = 1'b0; bp_cnt = 0;
          rc = rst_count;
          repeat (neuron_lat) @(negedge clk);
          if (rst_count == rc) begin
            neuron_sum = 10'(acc);
            overflow = (acc >= 1024);
            neuron_sum_valid = 1'b1;
            guard = 0;
            while (!neuron_sum_ready && rst_count == rc && guard < 100) begin
              @(negedge clk); guard++;
            end
            if (neuron_sum_ready && rst_count == rc) begin
              @(posedge clk); #1;
            end
            neuron_sum_valid = 1'b0;
          end
        end
      end
    end
  end

  // Monitor / scoreboard
  logic        held;
  logic [79:0] held_o;
  logic [7:0]  held_v;

  initial begin
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        held = 1'b0;
      end else begin
        if (weight_rd_en) begin
          if (exp_addr_q.size() == 0) chk("unexpected_rd_en", 80'(weight_rd_en), 80'(0));
          else chk("rd_addr", 80'(weight_rd_addr), 80'(exp_addr_q.pop_front()));
        end
        if (layer_outputs_valid) begin
          if (held) begin
            chk("hold_outputs", layer_outputs, held_o);
            chk("hold_overflow", 80'(layer_overflow), 80'(held_v));
          end
          if (layer_outputs_ready) begin
            if (exp_res_q.size() == 0) begin
              chk("unexpected_result", 80'(layer_outputs_valid), 80'(0));
            end else begin
              res_t e;
              e = exp_res_q.pop_front();
              chk("layer_outputs", layer_outputs, e.outs);
              chk("layer_overflow", 80'(layer_overflow), 80'(e.ovf));
            end
            held = 1'b0;
          end else begin
            held = 1'b1; held_o = layer_outputs; held_v = layer_overflow;
          end
        end else begin
          held = 1'b0;
        end
      end
    end
  end

  task automatic push_res(input logic [79:0] o, input logic [7:0] v);
    res_t r;
    r.outs = o; r.ovf = v;
    exp_res_q.push_back(r);
  endtask

  task automatic start_layer(input logic [49:0] vin, input logic [3:0] in_num,
                             input logic [3:0] nnum, input logic [7:0] base);
    int g;
    g = 0;
    while (!layer_ready && g < 200) begin @(posedge clk); #1; g++; end
    if (g >= 200) chk("start_timeout", 80'(layer_ready), 80'(1));
    layer_inputs = vin; layer_input_num = in_num; layer_neuron_num = nnum;
    layer_weight_base = base; cur_inputs = vin; layer_valid = 1'b1;
    @(posedge clk); #1;
    layer_valid = 1'b0;
  endtask

  task automatic wait_done();
    int g;
    g = 0;
    while ((exp_res_q.size() != 0 || exp_addr_q.size() != 0) && g < 300) begin
      @(posedge clk); #1; g++;
    end
    if (g >= 300) begin
      chk("layer_timeout", 80'(exp_res_q.size()), 80'(0));
      exp_res_q.delete(); exp_addr_q.delete();
    end
    @(posedge clk); #1;
  endtask

  logic [49:0] vin_a;
  int          rises, g2;
  logic        prev;

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; layer_valid = 1'b0; layer_input_num = '0; layer_neuron_num = '0;
    layer_weight_base = '0; layer_inputs = '0; input_number_ready = 1'b1;
    inputs_ready = 1'b1; weights_ready = 1'b1; layer_outputs_ready = 1'b1;
    bp_mode = 1'b0; neuron_lat = 1; exp_in_num = 4'd5; cur_inputs = '0;
    for (int r = 0; r < 256; r++) wmem[8'(r)] = '0;
    wmem[0]   = pk_w(10, 8, 6, 4, 2);
    wmem[1]   = pk_w(100, 80, 60, 40, 20);
    wmem[3]   = pk_w(10, 8, 6, 4, 2);
    wmem[4]   = pk_w(100, 80, 60, 40, 20);
    wmem[6]   = pk_w(500, 500, 500, 500, 500);
    wmem[7]   = pk_w(10, 8, 6, 4, 2);
    wmem[255] = pk_w(100, 80, 60, 40, 20);
    for (int k = 0; k < 8; k++) wmem[8'(16 + k)] = pk_w(k + 1, k + 1, k + 1, k + 1, k + 1);
    vin_a = pk_in(5, 4, 3, 2, 1);

    #2;
    chk("rst_layer_ready", 80'(layer_ready), 80'(1));
    chk("rst_out_valid", 80'(layer_outputs_valid), 80'(0));
    chk("rst_rd_en", 80'(weight_rd_en), 80'(0));
    chk("rst_nvalids", 80'({input_number_valid, inputs_valid, weights_valid}), 80'(0));
    chk("rst_sum_ready", 80'(neuron_sum_ready), 80'(0));
    chk("rst_outputs", layer_outputs, 80'(0));
    chk("rst_overflow", 80'(layer_overflow), 80'(0));
    chk("rst_data", 80'({input_number, weight_rd_addr}), 80'(0));
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    // single neuron: sum(x*w)=110, >>1 = 55
    exp_in_num = 4'd5;
    exp_addr_q.push_back(8'd0);
    push_res(pk_out(0, 0, 0, 0, 0, 0, 0, 55), 8'h00);
    start_layer(vin_a, 4'd5, 4'd1, 8'd0);
    wait_done();

    // two neurons from base 3, with a layer_valid pulse while busy
    exp_addr_q.push_back(8'd3); exp_addr_q.push_back(8'd4);
    push_res(pk_out(0, 0, 0, 0, 0, 0, 550, 55), 8'h00);
    start_layer(vin_a, 4'd5, 4'd2, 8'd3);
    @(posedge clk); #1;
    layer_inputs = pk_in(1, 1, 1, 1, 1); layer_neuron_num = 4'd1; layer_weight_base = 8'd0;
    layer_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      chk("busy_layer_ready", 80'(layer_ready), 80'(0));
      @(posedge clk); #1;
    end
    layer_valid = 1'b0;
    wait_done();

    // inputs channel backpressure
    bp_mode = 1'b1; inputs_ready = 1'b0;
    exp_addr_q.push_back(8'd0);
    push_res(pk_out(0, 0, 0, 0, 0, 0, 0, 55), 8'h00);
    start_layer(vin_a, 4'd5, 4'd1, 8'd0);
    wait_done();
    bp_mode = 1'b0; inputs_ready = 1'b1;

    // zero neurons: DONE immediately, no reads
    push_res(80'(0), 8'h00);
    start_layer(vin_a, 4'd5, 4'd0, 8'd0);
    chk("zero_done_next", 80'(layer_outputs_valid), 80'(1));
    wait_done();

    // saturation: 7 inputs -> 5, 12 neurons -> 8; inputs all 2, row k weights k+1 -> 5(k+1)
    exp_in_num = 4'd5;
    for (int k = 0; k < 8; k++) exp_addr_q.push_back(8'(16 + k));
    push_res(pk_out(40, 35, 30, 25, 20, 15, 10, 5), 8'h00);
    start_layer(pk_in(2, 2, 2, 2, 2), 4'd7, 4'd12, 8'd16);
    wait_done();

    // address wrap 255 -> 0
    exp_addr_q.push_back(8'd255); exp_addr_q.push_back(8'd0);
    push_res(pk_out(0, 0, 0, 0, 0, 0, 55, 550), 8'h00);
    start_layer(vin_a, 4'd5, 4'd2, 8'd255);
    wait_done();

    // 3 active inputs; row6 overflows: 6*500=3000>>1=1500 -> 476; row7: 28>>1=14
    exp_in_num = 4'd3;
    exp_addr_q.push_back(8'd6); exp_addr_q.push_back(8'd7);
    push_res(pk_out(0, 0, 0, 0, 0, 0, 14, 476), 8'h01);
    start_layer(vin_a, 4'd3, 4'd2, 8'd6);
    wait_done();

    // reset during COLLECT of neuron 1 of 3
    exp_in_num = 4'd5; neuron_lat = 4;
    exp_addr_q.push_back(8'd0); exp_addr_q.push_back(8'd1);
    start_layer(vin_a, 4'd5, 4'd3, 8'd0);
    rises = 0; g2 = 0; prev = 1'b0;
    while (rises < 2 && g2 < 200) begin
      @(negedge clk);
      if (neuron_sum_ready && !prev) rises++;
      prev = neuron_sum_ready; g2++;
    end
    if (g2 >= 200) chk("collect_timeout", 80'(rises), 80'(2));
    rst = 1'b0;
    #1;
    chk("midrst_layer_ready", 80'(layer_ready), 80'(1));
    chk("midrst_out_valid", 80'(layer_outputs_valid), 80'(0));
    chk("midrst_outputs", layer_outputs, 80'(0));
    chk("midrst_overflow", 80'(layer_overflow), 80'(0));
    chk("midrst_sum_ready", 80'(neuron_sum_ready), 80'(0));
    chk("midrst_weights", weights, 80'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    neuron_lat = 1;
    repeat (10) @(posedge clk);
    #1;
    chk("postrst_idle", 80'(layer_ready), 80'(1));
    chk("postrst_no_valid", 80'(layer_outputs_valid), 80'(0));

    // output backpressure: hold 4 cycles in DONE
    layer_outputs_ready = 1'b0;
    exp_addr_q.push_back(8'd0);
    push_res(pk_out(0, 0, 0, 0, 0, 0, 0, 55), 8'h00);
    start_layer(vin_a, 4'd5, 4'd1, 8'd0);
    g2 = 0;
    while (!layer_outputs_valid && g2 < 100) begin @(posedge clk); #1; g2++; end
    if (g2 >= 100) chk("done_timeout", 80'(layer_outputs_valid), 80'(1));
    repeat (4) begin
      chk("bp_out_valid_held", 80'(layer_outputs_valid), 80'(1));
      chk("bp_not_ready", 80'(layer_ready), 80'(0));
      @(posedge clk); #1;
    end
    layer_outputs_ready = 1'b1;
    @(posedge clk); #1;
    chk("after_xfer_ready", 80'(layer_ready), 80'(1));
    chk("after_xfer_valid", 80'(layer_outputs_valid), 80'(0));
    wait_done();

    chk("addr_queue_empty", 80'(exp_addr_q.size()), 80'(0));
    chk("res_queue_empty", 80'(exp_res_q.size()), 80'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
